intan_spi_master: RTL

- Parametrised SPI master for Intan RHD-family headstages. Successor to the fixed 16-bit, single-MISO, free-running Intan pattern generator.
- Takes commands over a valid/ready handshake and runs one CS-framed transfer per command.
- Samples N_MISO parallel MISO lines (one per chip on a shared CS/SCLK/MOSI) and returns all responses in one strobe.
- Optional auto-idle mode keeps the frame rate constant by sending a filler command when no command is pending.
- Sits between the acquisition sequencer and the headstage pins.

---
 rtl/intan_spi_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/intan_spi_master.sv
// Purpose : SPI master for Intan RHD headstages: one CS-framed WORD_W-bit transfer per
//           accepted command, N_MISO parallel response lines captured per frame.
// Latency : rsp_valid pulses CLK_DIV + 2*WORD_W*CLK_DIV + CLK_DIV cycles after acceptance;
//           frame period 1 + 2*CLK_DIV + 2*WORD_W*CLK_DIV + CS_HIGH_CYC cycles.
// Backpr. : cmd_ready is high only in IDLE with enable set; rsp side has no backpressure.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   enable                 permits new frames to start (a running frame always completes)
//   cmd_valid/ready/data   command handshake, data sent MSB first
//   rsp_valid/data/is_idle one-cycle strobe with all chip responses (chip k at [k*WORD_W +: WORD_W])
//   busy                   high whenever the FSM is outside IDLE
//   cs_n, sclk, mosi, miso headstage pins (sclk idles low, all pin outputs registered)
module intan_spi_master #(
  parameter int                WORD_W      = 16,
  parameter int                N_MISO      = 1,
  parameter int                CLK_DIV     = 1,
  parameter int                CS_HIGH_CYC = 8,
  parameter bit                AUTO_IDLE   = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_CMD    = WORD_W'(16'hE800)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WORD_W-1:0]          cmd_data,
  output logic                       rsp_valid,
  output logic [N_MISO*WORD_W-1:0]   rsp_data,
  output logic                       rsp_is_idle,
  output logic                       busy,
  output logic                       cs_n,
  output logic                       sclk,
  output logic                       mosi,
  input  logic [N_MISO-1:0]          miso
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_HIGH_CYC + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [DIV_W-1:0]                r_div_cnt;
  logic [BIT_W-1:0]                r_bit_cnt;
  logic [GAP_W-1:0]                r_gap_cnt;
  logic [WORD_W-1:0]               r_tx;
  logic [N_MISO-1:0][WORD_W-1:0]   r_shift;
  logic                            r_idle_flag;
  logic                            r_cs_n;
  logic                            r_sclk;
  logic                            r_mosi;
  logic                            r_rsp_valid;
  logic [N_MISO*WORD_W-1:0]        r_rsp_data;
  logic                            r_rsp_is_idle;

  logic                            w_div_last;
  logic                            w_bit_last;
  logic                            w_gap_last;
  logic                            w_cmd_ready;
  logic                            w_accept;
  logic                            w_load;
  logic                            w_rise;
  logic                            w_fall;
  logic                            w_done;
  logic [WORD_W-1:0]               w_load_word;

  assign w_div_last  = (r_div_cnt == DIV_LAST);
  assign w_bit_last  = (r_bit_cnt == BIT_LAST);
  assign w_gap_last  = (r_gap_cnt == GAP_LAST);
  assign w_accept    = w_cmd_ready & cmd_valid;
  // A real command always wins over the filler word in the same IDLE cycle.
  assign w_load_word = w_accept ? cmd_data : IDLE_CMD;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (enable && (cmd_valid || AUTO_IDLE)) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_div_last)                         w_state_nxt = ST_SHIFT;
      // Leave SHIFT only at the end of the last bit's low half.
      ST_SHIFT: if (!r_sclk && w_div_last && w_bit_last) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_div_last)                         w_state_nxt = ST_GAP;
      ST_GAP:   if (w_gap_last)                         w_state_nxt = ST_IDLE;
      default:                                          w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output decode
  // Strobes mark the clock edges at which the registered pins change.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_load      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = enable;
        w_load      = enable & (cmd_valid | AUTO_IDLE);
      end
      ST_SETUP: w_rise = w_div_last;
      ST_SHIFT: begin
        // r_sclk doubles as the half-period phase: high half vs low half.
        w_fall = r_sclk & w_div_last;
        w_rise = ~r_sclk & w_div_last & ~w_bit_last;
      end
      ST_HOLD: w_done = w_div_last;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_tx          <= '0;
      r_shift       <= '0;
      r_idle_flag   <= 1'b0;
      r_cs_n        <= 1'b1;
      r_sclk        <= 1'b0;
      r_mosi        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_is_idle <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      // Half-period timer runs through SETUP, SHIFT and HOLD, restarting every half.
      if (r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD) begin
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      end else begin
        r_div_cnt <= '0;
      end

      if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end

      if (w_load) begin
        r_cs_n      <= 1'b0;
        r_mosi      <= w_load_word[WORD_W-1];
        r_tx        <= w_load_word << 1;
        r_idle_flag <= ~w_accept;
        r_bit_cnt   <= '0;
        r_shift     <= '0;
      end

      if (w_rise) begin
        r_sclk <= 1'b1;
        for (int k = 0; k < N_MISO; k++) begin
          r_shift[k] <= {r_shift[k][WORD_W-2:0], miso[k]};
        end
        // The first rise comes from SETUP and starts bit 0; later rises start the next bit.
        if (r_state == ST_SHIFT) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_fall) begin
        r_sclk <= 1'b0;
        if (w_bit_last) begin
          r_mosi <= 1'b0;
        end else begin
          r_mosi <= r_tx[WORD_W-1];
          r_tx   <= r_tx << 1;
        end
      end

      if (w_done) begin
        r_cs_n        <= 1'b1;
        r_rsp_valid   <= 1'b1;
        r_rsp_data    <= r_shift;
        r_rsp_is_idle <= r_idle_flag;
      end
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign busy        = (r_state != ST_IDLE);
  assign cs_n        = r_cs_n;
  assign sclk        = r_sclk;
  assign mosi        = r_mosi;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_is_idle = r_rsp_is_idle;

endmodule
